// File: rtl/ps2_key_sched.sv
// ps2_key_sched
//   Merges physical keyboard events with injected (synthetic) events into a
//   single toggle-coded event stream for the keyboard matrix. Live events are
//   queued in a small FIFO and always win over the injector. Every emitted
//   event is followed by GAP idle cycles, so consecutive emissions are GAP+1
//   cycles apart.
//
// Ports
//   clk_sys    system clock, all logic on the rising edge
//   reset      synchronous, active-high reset
//   live_key   physical event: [10] toggle, [9] pressed, [8] extended, [7:0] scancode
//   inj_valid  injector offers inj_data
//   inj_data   injected event: [9] pressed, [8] extended, [7:0] scancode
//   inj_ready  injector transfer accepted this cycle (combinational)
//   ps2_key    merged event stream, same format as live_key
//   busy       scheduler in its gap or live events still queued
//   overflow   sticky: a live event was dropped because the FIFO was full
module ps2_key_sched #(
  parameter int unsigned GAP   = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] live_key,
  input  logic        inj_valid,
  input  logic [9:0]  inj_data,
  output logic        inj_ready,
  output logic [10:0] ps2_key,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [15:0] GAP_LOAD = 16'(GAP - 1);

  typedef enum logic {
    S_IDLE,
    S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [10:0]   key_q, key_d;
  logic          old_tog_q;
  logic          ovf_q;

  logic [9:0]    fifo_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic          live_evt;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push;
  logic          inj_xfer;

  // A live event is any change of the toggle bit relative to last cycle.
  assign live_evt   = live_key[10] ^ old_tog_q;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);

  // The scheduler drains the FIFO whenever it is idle; a pop frees a slot on
  // the same edge, so a live event arriving with a full FIFO is still taken.
  assign pop       = (state_q == S_IDLE) && !fifo_empty;
  assign push      = live_evt && (!fifo_full || pop);
  // Injector is held off while any live event is queued and during reset.
  assign inj_ready = !reset && (state_q == S_IDLE) && fifo_empty;
  assign inj_xfer  = inj_valid && inj_ready;

  assign ps2_key   = key_q;
  assign busy      = (state_q != S_IDLE) || !fifo_empty;
  assign overflow  = ovf_q;

  // NOTE: every signal assigned here gets a default first so no path through
  // the block leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          key_d   = {~key_q[10], fifo_q[rd_ptr_q]};
          cnt_d   = GAP_LOAD;
          state_d = S_GAP;
        end else if (inj_xfer) begin
          key_d   = {~key_q[10], inj_data};
          cnt_d   = GAP_LOAD;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      key_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      // Track the current toggle level so releasing reset is not an event.
      old_tog_q <= live_key[10];
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_q | (live_evt && !push);
      old_tog_q <= live_key[10];
    end
  end

  // NOTE: the FIFO storage has no reset; emptiness is defined by the pointers
  // and count, so stale entries are never read.
  always_ff @(posedge clk_sys) begin
    if (push && !reset) begin
      fifo_q[wr_ptr_q] <= live_key[9:0];
    end
  end

endmodule

// File: tb/tb_ps2_key_sched.sv
// tb_ps2_key_sched
//   Self-checking bench for ps2_key_sched. A behavioural model (event queue
//   plus "earliest next emission cycle") predicts every output each cycle;
//   directed scenarios pin key behaviours with literal expectations, then a
//   randomized phase exercises contention, bursts, overflow and resets.
module tb_ps2_key_sched;

  localparam int GAP   = 16;
  localparam int DEPTH = 4;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] live_key;
  logic        inj_valid;
  logic [9:0]  inj_data;
  logic        inj_ready;
  logic [10:0] ps2_key;
  logic        busy;
  logic        overflow;

  ps2_key_sched #(.GAP(GAP), .DEPTH(DEPTH)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .live_key (live_key),
    .inj_valid(inj_valid),
    .inj_data (inj_data),
    .inj_ready(inj_ready),
    .ps2_key  (ps2_key),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mq      : live events waiting for emission
  // next_ok : earliest edge index at which another emission may happen
  // cyc     : index of the next rising edge
  logic [9:0]  mq [$];
  int          next_ok = 0;
  int          cyc     = 0;
  logic [10:0] m_key   = '0;
  logic        m_ovf   = 1'b0;
  logic        m_old   = 1'b0;
  logic        m_valid = 1'b0;

  always @(posedge clk_sys) begin
    if (reset) begin
      mq.delete();
      m_key   = '0;
      m_ovf   = 1'b0;
      next_ok = cyc + 1;
      m_old   = live_key[10];
      m_valid = 1'b1;
    end else begin
      if (cyc >= next_ok) begin
        if (mq.size() > 0) begin
          m_key   = {~m_key[10], mq.pop_front()};
          next_ok = cyc + GAP + 1;
        end else if (inj_valid) begin
          m_key   = {~m_key[10], inj_data};
          next_ok = cyc + GAP + 1;
        end
      end
      if (live_key[10] != m_old) begin
        if (mq.size() < DEPTH) mq.push_back(live_key[9:0]);
        else m_ovf = 1'b1;
      end
      m_old = live_key[10];
    end
    cyc++;
  end

  // One compare process, mid-cycle, for every cycle after the first reset.
  always @(negedge clk_sys) begin
    if (m_valid) begin
      logic e_busy, e_ready;
      e_busy  = (mq.size() != 0) || (cyc < next_ok);
      e_ready = !reset && (cyc >= next_ok) && (mq.size() == 0);
      check("cmp_ps2_key",   32'(ps2_key),   32'(m_key));
      check("cmp_busy",      32'(busy),      32'(e_busy));
      check("cmp_overflow",  32'(overflow),  32'(m_ovf));
      check("cmp_inj_ready", 32'(inj_ready), 32'(e_ready));
    end
  end

  // Emission log: edge index (plus one) and value of every ps2_key change.
  logic [10:0] last_key = '0;
  int          log_cyc [$];
  logic [10:0] log_key [$];

  always @(negedge clk_sys) begin
    if (m_valid) begin
      if (ps2_key !== last_key) begin
        log_cyc.push_back(cyc);
        log_key.push_back(ps2_key);
      end
      last_key = ps2_key;
    end
  end

  task automatic clear_log();
    log_cyc.delete();
    log_key.delete();
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_sys);
      if (!busy) break;
    end
    check(name, 32'(busy), 32'd0);
    tick();
  endtask

  task automatic check_spacing(input string name);
    for (int i = 1; i < log_cyc.size(); i++) begin
      check(name, 32'(log_cyc[i] - log_cyc[i-1]), 32'(GAP + 1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          p;
    logic [9:0]  inj_seq [3];

    inj_seq = '{10'h251, 10'h052, 10'h2A3};

    reset     = 1'b1;
    live_key  = '0;
    inj_valid = 1'b0;
    inj_data  = '0;
    tick(); tick(); tick();

    // Reset state
    check("rst_ps2_key",   32'(ps2_key),   32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_overflow",  32'(overflow),  32'h0);
    check("rst_inj_ready", 32'(inj_ready), 32'h0);
    reset = 1'b0;
    #1;
    check("post_rst_inj_ready", 32'(inj_ready), 32'h1);
    tick();

    // Single live event: latency of one edge, busy for GAP+1 cycles
    clear_log();
    live_key = {1'b1, 1'b1, 1'b0, 8'h1C};
    tick();
    check("single_key_before", 32'(ps2_key), 32'h0);
    check("single_busy_queued", 32'(busy), 32'h1);
    n = 1;
    tick();
    check("single_key", 32'(ps2_key), 32'h61C);
    check("single_model_key", 32'(m_key), 32'h61C);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_sys);
      if (busy) n++;
      else break;
    end
    check("single_busy_len", 32'(n), 32'(GAP + 1));
    tick();

    // Contention: live 0x12 first, injected 0x29 GAP+1 cycles later
    clear_log();
    live_key = {1'b0, 1'b1, 1'b0, 8'h12};
    tick();
    inj_data  = {1'b1, 1'b0, 8'h29};
    inj_valid = 1'b1;
    #1;
    check("contend_ready_held", 32'(inj_ready), 32'h0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_sys);
      if (log_key.size() >= 2) break;
    end
    tick();
    inj_valid = 1'b0;
    wait_idle("contend_idle");
    check("contend_count", 32'(log_key.size()), 32'd2);
    if (log_key.size() == 2) begin
      check("contend_first",  32'(log_key[0][9:0]), 32'h212);
      check("contend_second", 32'(log_key[1][9:0]), 32'h229);
      check_spacing("contend_spacing");
    end

    // Burst of 6 live toggles: 5 emitted in order, 6th dropped
    clear_log();
    for (int i = 0; i < 6; i++) begin
      live_key = {~live_key[10], 1'b1, 1'b0, 8'(8'h30 + i)};
      tick();
    end
    check("burst_overflow", 32'(overflow), 32'h1);
    wait_idle("burst_idle");
    check("burst_count", 32'(log_key.size()), 32'd5);
    if (log_key.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check("burst_order", 32'(log_key[i][9:0]), 32'(10'h230 + i));
      end
      check_spacing("burst_spacing");
    end

    // Reset mid-operation with 3 events queued and live_key[10]=1
    for (int i = 0; i < 4; i++) begin
      live_key = {~live_key[10], 1'b1, 1'b0, 8'(8'h60 + i)};
      tick();
    end
    reset    = 1'b1;
    live_key = {1'b1, 10'h0AA};
    tick(); tick();
    reset = 1'b0;
    #1;
    check("midrst_ps2_key",  32'(ps2_key),  32'h0);
    check("midrst_busy",     32'(busy),     32'h0);
    check("midrst_overflow", 32'(overflow), 32'h0);
    clear_log();
    repeat (40) tick();
    check("midrst_no_emit", 32'(log_key.size()), 32'd0);
    check("midrst_still_idle", 32'(busy), 32'h0);

    // Full FIFO with a live event on the pop edge: accepted, no overflow
    clear_log();
    for (int i = 0; i < 5; i++) begin
      live_key = {~live_key[10], 1'b0, 1'b1, 8'(8'h40 + i)};
      tick();
    end
    repeat (GAP - 3) tick();
    live_key = {~live_key[10], 1'b0, 1'b1, 8'h45};
    tick();
    check("fullpop_overflow", 32'(overflow), 32'h0);
    wait_idle("fullpop_idle");
    check("fullpop_overflow_end", 32'(overflow), 32'h0);
    check("fullpop_count", 32'(log_key.size()), 32'd6);
    if (log_key.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check("fullpop_order", 32'(log_key[i][9:0]), 32'(10'h140 + i));
      end
      check_spacing("fullpop_spacing");
    end

    // Injector stream: three transfers, toggle 0->1->0->1, GAP+1 apart
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    clear_log();
    inj_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      inj_data = inj_seq[j];
      for (int i = 0; i < 100; i++) begin
        tick();
        if (ps2_key[9:0] == inj_seq[j]) break;
      end
      if (j < 2) begin
        // Garbage while the injector is held off must be ignored.
        inj_data = 10'h3FF;
        repeat (GAP - 2) tick();
      end
    end
    inj_valid = 1'b0;
    wait_idle("inj_idle");
    check("inj_count", 32'(log_key.size()), 32'd3);
    if (log_key.size() == 3) begin
      for (int j = 0; j < 3; j++) begin
        check("inj_data",   32'(log_key[j][9:0]), 32'(inj_seq[j]));
        check("inj_toggle", 32'(log_key[j][10]),  32'((j % 2) == 0));
      end
      check_spacing("inj_spacing");
    end

    // Randomized traffic checked against the model every cycle
    p = 5;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(2))
          0:       p = 2;
          1:       p = 15;
          default: p = 70;
        endcase
      end
      if ($urandom_range(99) < p) live_key = {~live_key[10], 10'($urandom)};
      else if ($urandom_range(7) == 0) live_key[9:0] = 10'($urandom);
      inj_valid = ($urandom_range(1) == 1);
      inj_data  = 10'($urandom);
      reset     = ($urandom_range(599) == 0);
      tick();
    end
    reset     = 1'b0;
    inj_valid = 1'b0;
    wait_idle("random_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_sched.md
PS2_KEY_SCHED -- requirements
Module: ps2_key_sched

Interface
REQ-001 SHALL have parameter GAP, default 16: idle cycles enforced after every emitted event; legal range 1..65535.
REQ-002 SHALL have parameter DEPTH, default 4: live-event FIFO depth; power of two, 2..16.
REQ-003 SHALL have port clk_sys  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port live_key  input  11  physical keyboard event: [10] toggle, [9] pressed, [8] extended, [7:0] scancode.
REQ-006 SHALL have port inj_valid  input  1  injector has an event on inj_data.
REQ-007 SHALL have port inj_data  input  10  injected event: [9] pressed, [8] extended, [7:0] scancode.
REQ-008 SHALL have port inj_ready  output  1  scheduler accepts inj_data this cycle.
REQ-009 SHALL have port ps2_key  output  11  merged event stream to the keyboard matrix, same format as live_key.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE or the FIFO is non-empty.
REQ-011 SHALL have port overflow  output  1  sticky: a live event was dropped.

Function
REQ-012 SHALL register old_tog; a live event is detected on any edge where live_key[10] != old_tog; old_tog <= live_key[10] every cycle.
REQ-013 SHALL push live_key[9:0] into the FIFO on the detecting edge when not full.
REQ-014 SHALL drop a live event arriving while FIFO is full and no pop occurs that edge, and set overflow to 1 until reset.
REQ-015 SHALL allow push and pop on the same edge; a simultaneous push with full FIFO and pop SHALL succeed with no overflow.
REQ-016 SHALL implement states IDLE, GAP only.
REQ-017 IDLE, FIFO non-empty: SHALL pop head, set ps2_key[9:0] to it, invert ps2_key[10], load gap counter with GAP-1, go to GAP.
REQ-018 IDLE, FIFO empty, inj_valid=1: SHALL set ps2_key[9:0] <= inj_data, invert ps2_key[10], load counter, go to GAP.
REQ-019 inj_ready SHALL be combinational: 1 iff state==IDLE and FIFO empty; transfer occurs iff inj_valid && inj_ready.
REQ-020 Live events SHALL have strict priority over injected events; the injector is held off (inj_ready=0) while any live event is queued.
REQ-021 GAP: counter SHALL decrement each cycle; on the edge where it is 0, go to IDLE.
REQ-022 Consecutive emissions (ps2_key[10] toggles) SHALL be exactly GAP+1 cycles apart when work is continuously pending.
REQ-023 Live event latency, idle scheduler, empty FIFO: toggle present at edge k -> ps2_key updated at edge k+1.
REQ-024 ps2_key SHALL change only at an emission; each emission SHALL toggle bit 10 exactly once.
REQ-025 FIFO order SHALL be preserved; no live event SHALL be duplicated or reordered.
REQ-026 Injector data SHALL be sampled only on the transfer edge; inj_data changes while inj_ready=0 SHALL have no effect.

Reset
REQ-027 On reset SHALL set ps2_key=0, state=IDLE, counter=0, FIFO empty, overflow=0.
REQ-028 On reset SHALL load old_tog <= live_key[10], so no spurious event is produced after reset release.
REQ-029 Reset mid-GAP or with a queued FIFO SHALL discard all pending events; inj_ready SHALL be 0 during reset.

Verification
REQ-030 Single live event: live_key toggles to {1,1,0,0x1C}, idle -> ps2_key = 11'h61C at next edge; busy high for GAP+1 cycles.
REQ-031 Contention: inj_valid=1 with 0x29 held while live 0x12 arrives -> 0x12 emitted first, inj_ready=0 until FIFO empty and GAP ends, then 0x29 emitted GAP+1 cycles later.
REQ-032 Burst: 6 live toggles on 6 consecutive cycles, DEPTH=4, GAP=16 -> first emitted at once, next 4 queued, 6th dropped, overflow=1; 5 emissions spaced 17 cycles, in order.
REQ-033 Full-with-pop: FIFO full, live event on the same edge the scheduler pops -> accepted, overflow stays 0.
REQ-034 Reset mid-operation: reset asserted with 3 events queued and live_key[10]=1 -> ps2_key=0, busy=0 after reset, no emission after release until live_key[10] changes.
REQ-035 Injector stream: inj_valid held high with 3 events -> three transfers, ps2_key[10] toggles 0->1->0->1, exactly GAP+1 cycles apart.
